// File: rtl/lsrt_pkg.sv
// Shared constants and small helpers for the UART receive path and its buffering.
package lsrt_pkg;

   localparam int UART_DMSB = 7;
   localparam logic [UART_DMSB:0] UART_LF = 8'h0A;

   typedef logic [UART_DMSB:0] byte_t;

   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_PUSH = 2'b01,
      FIFO_POP  = 2'b10,
      FIFO_BOTH = 2'b11
   } fifoOp_e;

   // Collapses the accepted push/pop pair into one operation code.
   function automatic fifoOp_e fifoOp(input logic push, input logic pop);
      return fifoOp_e'({pop, push});
   endfunction

endpackage

// File: rtl/lsrt_sfifo.sv
// Generic synchronous first-word-fall-through FIFO with flush and fill-level flags.
module lsrt_sfifo
   import lsrt_pkg::*;
#(
   parameter int DMSB = UART_DMSB,
   parameter int AMSB = 3
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [DMSB:0] pushData_i,
   input  logic          pop_i,
   output logic [DMSB:0] data_o,
   output logic          empty_o,
   output logic          afull_o,
   output logic [AMSB+1:0] count_o,
   output logic          pushOk_o,
   output logic          popOk_o
);

   localparam int CNT_W = AMSB + 2;
   localparam int DEPTH = 2 ** (AMSB + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(DEPTH - 2);

   logic [DMSB:0]    mem_q [DEPTH];
   logic [AMSB:0]    wPtr_q, wPtr_d;
   logic [AMSB:0]    rPtr_q, rPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             popOk, pushOk;
   fifoOp_e          op;

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   always_comb begin
      popOk   = pop_i && (count_q != '0) && !flush_i;
      pushOk  = push_i && !flush_i && ((count_q != DEPTH_C) || popOk);
      op      = fifoOp(pushOk, popOk);
      wPtr_d  = wPtr_q;
      rPtr_d  = rPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wPtr_d  = '0;
         rPtr_d  = '0;
         count_d = '0;
      end else begin
         case (op)
            FIFO_PUSH: begin
               wPtr_d  = wPtr_q + 1'b1;
               count_d = count_q + 1'b1;
            end
            FIFO_POP: begin
               rPtr_d  = rPtr_q + 1'b1;
               count_d = count_q - 1'b1;
            end
            FIFO_BOTH: begin
               wPtr_d = wPtr_q + 1'b1;
               rPtr_d = rPtr_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wPtr_q  <= '0;
         rPtr_q  <= '0;
         count_q <= '0;
      end else begin
         wPtr_q  <= wPtr_d;
         rPtr_q  <= rPtr_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; its contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem_q[wPtr_q] <= pushData_i;
      end
   end

   assign data_o   = mem_q[rPtr_q];
   assign empty_o  = (count_q == '0);
   assign afull_o  = (count_q >= AFULL_C);
   assign count_o  = count_q;
   assign pushOk_o = pushOk;
   assign popOk_o  = popOk;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: captures a byte per rising edge of full, with
// overflow tracking and a count of buffered line terminators.
module uart_rx_fifo
   import lsrt_pkg::*;
#(
   parameter int            DMSB = UART_DMSB,
   parameter int            AMSB = 3,
   parameter logic [DMSB:0] LF   = (DMSB+1)'(UART_LF)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            setn,
   input  logic            full,
   input  logic [DMSB:0]   rdata,
   output logic            clear,
   input  logic            flush,
   input  logic            pop,
   output logic [DMSB:0]   dout,
   output logic            empty,
   output logic            afull,
   output logic [AMSB+1:0] count,
   output logic [AMSB+1:0] lines,
   output logic            ovf
);

   logic [1:0]      fullSync_q, fullSync_d;
   logic            clear_q, clear_d;
   logic            ovf_q, ovf_d;
   logic [AMSB+1:0] lines_q, lines_d;
   logic            fl, cap;
   logic            pushOk, popOk;

   assign fl  = ~setn | flush;
   assign cap = (fullSync_q == 2'b01) && !fl;

   lsrt_sfifo #(
      .DMSB (DMSB),
      .AMSB (AMSB)
   ) uFifo (
      .clk        (clk),
      .rstn       (rstn),
      .flush_i    (fl),
      .push_i     (cap),
      .pushData_i (rdata),
      .pop_i      (pop),
      .data_o     (dout),
      .empty_o    (empty),
      .afull_o    (afull),
      .count_o    (count),
      .pushOk_o   (pushOk),
      .popOk_o    (popOk)
   );

   // A capture the FIFO refused can only mean it was full with no pop.
   always_comb begin
      fullSync_d = fl ? 2'b00 : {fullSync_q[0], full};
      clear_d    = fl;
      ovf_d      = ovf_q;
      lines_d    = lines_q;
      if (fl) begin
         ovf_d   = 1'b0;
         lines_d = '0;
      end else begin
         if (cap && !pushOk) begin
            ovf_d = 1'b1;
         end
         case ({pushOk && (rdata == LF), popOk && (dout == LF)})
            2'b10:   lines_d = lines_q + 1'b1;
            2'b01:   lines_d = lines_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fullSync_q <= 2'b00;
         clear_q    <= 1'b0;
         ovf_q      <= 1'b0;
         lines_q    <= '0;
      end else begin
         fullSync_q <= fullSync_d;
         clear_q    <= clear_d;
         ovf_q      <= ovf_d;
         lines_q    <= lines_d;
      end
   end

   assign clear = clear_q;
   assign ovf   = ovf_q;
   assign lines = lines_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo: stimulus queues expected bytes,
// a negedge monitor checks every byte the host pops.
module tb_uart_rx_fifo;
   import lsrt_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       setn = 1'b1;
   logic       full = 1'b0;
   logic       flush = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] rdata = 8'h00;
   logic       clear, empty, afull, ovf;
   logic [7:0] dout;
   logic [4:0] count, lines;

   int    checks = 0;
   int    errors = 0;
   byte_t expQ[$];
   byte_t expByte;

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .clk   (clk),
      .rstn  (rstn),
      .setn  (setn),
      .full  (full),
      .rdata (rdata),
      .clear (clear),
      .flush (flush),
      .pop   (pop),
      .dout  (dout),
      .empty (empty),
      .afull (afull),
      .count (count),
      .lines (lines),
      .ovf   (ovf)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One uart_rx delivery: full held high for 3 edges, then low for 2.
   task automatic applyStimulus(input byte_t b, input bit expectStored);
      @(posedge clk);
      #1 rdata = b;
      full = 1'b1;
      if (expectStored) expQ.push_back(b);
      repeat (3) @(posedge clk);
      #1 full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic popN(input int n);
      @(posedge clk);
      #1 pop = 1'b1;
      repeat (n) @(posedge clk);
      #1 pop = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rstn && setn && !flush && pop && !empty) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL pop_data: got %0h expected no byte at %0t", dout, $time);
         end else begin
            expByte = expQ.pop_front();
            if (dout !== expByte) begin
               errors++;
               $display("[TB] FAIL pop_data: got %0h expected %0h at %0t", dout, expByte, $time);
            end
         end
      end
   end

   initial begin
      byte_t seqBytes [4];
      int    seqLines [4];
      seqBytes = '{8'h3A, 8'h0A, 8'h3B, 8'h0A};
      seqLines = '{0, 1, 1, 2};

      #2;
      checkOutput("rst_empty", 32'(empty), 1);
      checkOutput("rst_afull", 32'(afull), 0);
      checkOutput("rst_clear", 32'(clear), 0);
      checkOutput("rst_count", 32'(count), 0);
      checkOutput("rst_lines", 32'(lines), 0);
      checkOutput("rst_ovf",   32'(ovf),   0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      $display("[TB] single byte with long full pulse");
      @(posedge clk);
      #1 rdata = 8'h41;
      full = 1'b1;
      expQ.push_back(8'h41);
      @(posedge clk);
      @(negedge clk);
      checkOutput("lat_count_early", 32'(count), 0);
      checkOutput("lat_empty_early", 32'(empty), 1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("lat_count", 32'(count), 1);
      repeat (46) @(posedge clk);
      @(negedge clk);
      checkOutput("one_count", 32'(count), 1);
      checkOutput("one_dout",  32'(dout),  32'h41);
      checkOutput("one_empty", 32'(empty), 0);
      checkOutput("one_lines", 32'(lines), 0);
      @(posedge clk);
      #1 full = 1'b0;
      repeat (2) @(posedge clk);
      popN(1);
      @(negedge clk);
      checkOutput("one_drained", 32'(empty), 1);

      $display("[TB] line counting");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(seqBytes[i], 1'b1);
         @(negedge clk);
         checkOutput("lines_inc", 32'(lines), 32'(seqLines[i]));
      end
      popN(1);
      @(negedge clk);
      checkOutput("lines_pop1", 32'(lines), 2);
      popN(1);
      @(negedge clk);
      checkOutput("lines_pop2", 32'(lines), 1);
      checkOutput("lines_count", 32'(count), 2);
      checkOutput("lines_dout", 32'(dout), 32'h3B);
      popN(2);
      @(negedge clk);
      checkOutput("lines_zero", 32'(lines), 0);
      checkOutput("lines_empty_count", 32'(count), 0);

      $display("[TB] overflow with 17 bytes");
      for (int i = 0; i <= 16; i++) begin
         applyStimulus(8'(8'h50 + i), i < 16);
         @(negedge clk);
         checkOutput("ovf_count", 32'(count), 32'((i < 16) ? i + 1 : 16));
         checkOutput("ovf_afull", 32'(afull), 32'(i >= 13));
         checkOutput("ovf_flag",  32'(ovf),   32'(i == 16));
      end
      popN(16);
      @(negedge clk);
      checkOutput("ovf_drained", 32'(empty), 1);
      checkOutput("ovf_sticky", 32'(ovf), 1);

      $display("[TB] pops on empty FIFO");
      popN(5);
      @(negedge clk);
      checkOutput("underflow_count", 32'(count), 0);
      checkOutput("underflow_empty", 32'(empty), 1);
      applyStimulus(8'h77, 1'b1);
      @(negedge clk);
      checkOutput("underflow_wr_dout", 32'(dout), 32'h77);
      popN(1);

      $display("[TB] flush pulse");
      applyStimulus(8'h31, 1'b0);
      applyStimulus(8'h0A, 1'b0);
      applyStimulus(8'h32, 1'b0);
      applyStimulus(8'h33, 1'b0);
      applyStimulus(8'h34, 1'b0);
      @(negedge clk);
      checkOutput("pre_flush_count", 32'(count), 5);
      checkOutput("pre_flush_lines", 32'(lines), 1);
      checkOutput("pre_flush_ovf",   32'(ovf),   1);
      @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      checkOutput("flush_clear_lag", 32'(clear), 0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_count", 32'(count), 0);
      checkOutput("flush_lines", 32'(lines), 0);
      checkOutput("flush_ovf",   32'(ovf),   0);
      checkOutput("flush_empty", 32'(empty), 1);
      checkOutput("flush_clear", 32'(clear), 1);
      @(negedge clk);
      checkOutput("flush_clear_end", 32'(clear), 0);

      $display("[TB] simultaneous capture and pop while full");
      for (int i = 0; i < 16; i++) applyStimulus(8'(8'h60 + i), 1'b1);
      @(negedge clk);
      checkOutput("full_count", 32'(count), 16);
      checkOutput("full_ovf",   32'(ovf),   0);
      @(posedge clk);
      #1 rdata = 8'hA5;
      full = 1'b1;
      expQ.push_back(8'hA5);
      @(posedge clk);
      #1 pop = 1'b1;
      @(posedge clk);
      #1 pop = 1'b0;
      @(negedge clk);
      checkOutput("both_count", 32'(count), 16);
      checkOutput("both_ovf",   32'(ovf),   0);
      @(posedge clk);
      #1 full = 1'b0;
      repeat (2) @(posedge clk);
      popN(16);
      @(negedge clk);
      checkOutput("both_drained", 32'(empty), 1);

      $display("[TB] setn dropped while full is high");
      applyStimulus(8'hC1, 1'b0);
      @(negedge clk);
      checkOutput("setn_pre_count", 32'(count), 1);
      @(posedge clk);
      #1 rdata = 8'hC2;
      full = 1'b1;
      setn = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("setn_count", 32'(count), 0);
      checkOutput("setn_clear", 32'(clear), 1);
      @(posedge clk);
      #1 full = 1'b0;
      repeat (2) @(posedge clk);
      #1 setn = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("setn_no_cap", 32'(count), 0);
      checkOutput("setn_clear_end", 32'(clear), 0);
      applyStimulus(8'hC3, 1'b1);
      @(negedge clk);
      checkOutput("setn_next_rise", 32'(count), 1);
      checkOutput("setn_next_dout", 32'(dout), 32'hC3);
      popN(1);

      $display("[TB] asynchronous reset mid-stream");
      for (int i = 0; i <= 16; i++) applyStimulus((i == 5) ? 8'h0A : 8'(8'h80 + i), 1'b0);
      @(negedge clk);
      checkOutput("prerst_count", 32'(count), 16);
      checkOutput("prerst_lines", 32'(lines), 1);
      checkOutput("prerst_ovf",   32'(ovf),   1);
      @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      checkOutput("arst_empty", 32'(empty), 1);
      checkOutput("arst_afull", 32'(afull), 0);
      checkOutput("arst_count", 32'(count), 0);
      checkOutput("arst_lines", 32'(lines), 0);
      checkOutput("arst_ovf",   32'(ovf),   0);
      checkOutput("arst_clear", 32'(clear), 0);
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(8'hE7, 1'b1);
      @(negedge clk);
      checkOutput("post_rst_count", 32'(count), 1);
      popN(1);
      @(negedge clk);
      checkOutput("post_rst_empty", 32'(empty), 1);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
